// File: rtl/machine_timer.sv
// machine_timer: memory-mapped mtime/mtimecmp timer with a one-shot interrupt.
// Define MACHINE_TIMER_PRESCALER_EN to build the 8-bit mtime prescaler.
module machine_timer #(
   parameter logic [31:0] RESET_COMPARE = 32'hFFFF_FFFF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        chipSelect,
   input  logic [3:0]  busAddress,
   input  logic        writeEnable,
   input  logic [31:0] writeData,
   output logic [31:0] readData,
   input  logic        trapReturn,
   output logic        timerInterrupt,
   output logic        timerMatch
);

   localparam logic [1:0] IDLE       = 2'd0;
   localparam logic [1:0] FIRE       = 2'd1;
   localparam logic [1:0] IN_SERVICE = 2'd2;

   logic [31:0] mtime;
   logic [31:0] mtimecmp;
   logic        enable;
   logic        irq_enable;
   logic [7:0]  prescale;
   logic        pending;
   logic        match_prev;
   logic [1:0]  state;

   logic        wr;
   logic        wr_time;
   logic        wr_cmp;
   logic        wr_ctrl;
   logic        wr_status;
   logic        match;
   logic        rise;
   logic        deliver;
   logic        step;
   logic        unused_bits;

   assign wr        = chipSelect && writeEnable;
   assign wr_time   = wr && (busAddress[3:2] == 2'd0);
   assign wr_cmp    = wr && (busAddress[3:2] == 2'd1);
   assign wr_ctrl   = wr && (busAddress[3:2] == 2'd2);
   assign wr_status = wr && (busAddress[3:2] == 2'd3);

   assign match   = enable && (mtime >= mtimecmp);
   assign rise    = match && !match_prev;
   assign deliver = (state == IDLE) && pending && irq_enable;

   assign timerMatch     = match;
   assign timerInterrupt = (state == FIRE);
   assign unused_bits    = ^{busAddress[1:0], writeData[31:2]};

`ifdef MACHINE_TIMER_PRESCALER_EN
   logic [7:0] pre_count;

   assign step = enable && (pre_count == prescale);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pre_count <= 8'd0;
         prescale  <= 8'd0;
      end else begin
         if (wr_time || step)
            pre_count <= 8'd0;
         else if (enable)
            pre_count <= pre_count + 8'd1;
         if (wr_ctrl)
            prescale <= writeData[15:8];
      end
   end
`else
   assign step     = enable;
   assign prescale = 8'd0;
`endif

   // A bus write to mtime takes priority over the increment.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mtime      <= 32'd0;
         mtimecmp   <= RESET_COMPARE;
         enable     <= 1'b0;
         irq_enable <= 1'b0;
         match_prev <= 1'b0;
      end else begin
         if (wr_time)
            mtime <= writeData;
         else if (step)
            mtime <= mtime + 32'd1;
         if (wr_cmp)
            mtimecmp <= writeData;
         if (wr_ctrl) begin
            enable     <= writeData[0];
            irq_enable <= writeData[1];
         end
         match_prev <= wr_cmp ? 1'b0 : match;
      end
   end

   // A new match edge beats any clear in the same cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         pending <= 1'b0;
      else if (rise)
         pending <= 1'b1;
      else if (deliver || (wr_status && writeData[0]))
         pending <= 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         unique case (state)
            IDLE:       if (deliver) state <= FIRE;
            FIRE:       state <= IN_SERVICE;
            IN_SERVICE: if (trapReturn) state <= IDLE;
            default:    state <= IDLE;
         endcase
      end
   end

   always_comb begin
      readData = 32'd0;
      if (chipSelect) begin
         unique case (busAddress[3:2])
            2'd0:    readData = mtime;
            2'd1:    readData = mtimecmp;
            2'd2:    readData = {16'd0, prescale, 6'd0, irq_enable, enable};
            default: readData = {30'd0, state != IDLE, pending};
         endcase
      end
   end

endmodule

// File: tb/tb_machine_timer.sv
// tb_machine_timer: directed scenarios plus random bus traffic
// compared against a cycle-level behavioural model of the timer.
module tb_machine_timer;

`ifdef MACHINE_TIMER_PRESCALER_EN
   localparam bit PRE = 1'b1;
`else
   localparam bit PRE = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        cs;
   logic [3:0]  addr;
   logic        we;
   logic [31:0] wdata;
   logic [31:0] readData;
   logic        trap;
   logic        timerInterrupt;
   logic        timerMatch;

   int tests = 0;
   int fails = 0;

   machine_timer dut (
      .clk(clk),
      .reset(reset),
      .chipSelect(cs),
      .busAddress(addr),
      .writeEnable(we),
      .writeData(wdata),
      .readData(readData),
      .trapReturn(trap),
      .timerInterrupt(timerInterrupt),
      .timerMatch(timerMatch)
   );

   always #10 clk = ~clk;

   // reference model state
   logic [31:0] m_time;
   logic [31:0] m_cmp;
   logic        m_en;
   logic        m_irqen;
   logic [7:0]  m_pre;
   logic [7:0]  m_ticks;
   logic        m_pend;
   logic        m_prev;
   logic        m_firing;
   logic        m_serving;

   task automatic model_reset();
      m_time = 0; m_cmp = 32'hFFFF_FFFF;
      m_en = 0; m_irqen = 0; m_pre = 0; m_ticks = 0;
      m_pend = 0; m_prev = 0; m_firing = 0; m_serving = 0;
   endtask

   function automatic logic m_match();
      return m_en && (m_time >= m_cmp);
   endfunction

   function automatic logic [31:0] m_read(input logic [1:0] a);
      case (a)
         2'd0: return m_time;
         2'd1: return m_cmp;
         2'd2: return {16'd0, m_pre, 6'd0, m_irqen, m_en};
         default: return {30'd0, m_firing || m_serving, m_pend};
      endcase
   endfunction

   task automatic model_step();
      logic w;
      logic [1:0] a;
      logic mt, rise, deliver;
      logic [31:0] n_time;
      logic [7:0] n_ticks;
      logic n_pend;
      w = cs && we;
      a = addr[3:2];
      mt = m_match();
      rise = mt && !m_prev;
      deliver = !m_firing && !m_serving && m_pend && m_irqen;
      n_time = m_time;
      n_ticks = m_ticks;
      if (m_en) begin
         if (m_ticks == m_pre) begin
            n_time = m_time + 1;
            n_ticks = 0;
         end else begin
            n_ticks = m_ticks + 1;
         end
      end
      if (w && a == 2'd0) begin
         n_time = wdata;
         n_ticks = 0;
      end
      n_pend = m_pend;
      if (deliver || (w && a == 2'd3 && wdata[0])) n_pend = 0;
      if (rise) n_pend = 1;
      m_prev = (w && a == 2'd1) ? 1'b0 : mt;
      m_serving = m_firing || (m_serving && !trap);
      m_firing = deliver;
      m_pend = n_pend;
      m_time = n_time;
      m_ticks = n_ticks;
      if (w && a == 2'd1) m_cmp = wdata;
      if (w && a == 2'd2) begin
         m_en = wdata[0];
         m_irqen = wdata[1];
         m_pre = PRE ? wdata[15:8] : 8'd0;
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d);
      cs = 1; we = 1; addr = a; wdata = d;
      tick();
      cs = 0; we = 0; addr = 0; wdata = 0;
   endtask

   task automatic check_reg(input string tag, input logic [3:0] a,
                            input logic [31:0] exp);
      logic [31:0] d;
      cs = 1; we = 0; addr = a;
      #1;
      d = readData;
      cs = 0; addr = 0;
      check(tag, d, exp);
   endtask

   task automatic wait_irq(input int max);
      int n;
      n = 0;
      while (!timerInterrupt && n < max) begin
         tick();
         n++;
      end
      check("wait_irq", {31'd0, timerInterrupt}, 32'd1);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      int pulses;
      logic [31:0] t;
      logic [1:0] a;
      logic [31:0] d;
      int r;
      reset = 1; cs = 0; we = 0; addr = 0; wdata = 0; trap = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst_irq", {31'd0, timerInterrupt}, 0);
      check("rst_match", {31'd0, timerMatch}, 0);
      check_reg("rst_mtime", 4'h0, 0);
      check_reg("rst_cmp", 4'h4, 32'hFFFF_FFFF);
      check_reg("rst_ctrl", 4'h8, 0);
      check_reg("rst_status", 4'hC, 0);
      reset = 0;

      // basic fire at mtime == 5
      wr(4'h4, 32'd5);
      wr(4'h8, 32'h3);
      repeat (5) tick();
      check_reg("mtime_5", 4'h0, 5);
      check_reg("mtime_5_alias", 4'h3, 5);
      #1;
      check("cs_low_read", readData, 0);
      check("match_5", {31'd0, timerMatch}, 1);
      check("irq_n", {31'd0, timerInterrupt}, 0);
      tick();
      check("irq_n1", {31'd0, timerInterrupt}, 0);
      check_reg("pend_n1", 4'hC, 1);
      tick();
      check("irq_n2", {31'd0, timerInterrupt}, 1);
      tick();
      check("irq_n3", {31'd0, timerInterrupt}, 0);
      check_reg("insvc", 4'hC, 2);

      // held match never re-fires
      pulses = 0;
      repeat (20) begin
         tick();
         if (timerInterrupt) pulses++;
      end
      check("held_pulses", pulses, 0);
      check_reg("held_insvc", 4'hC, 2);
      trap = 1;
      tick();
      trap = 0;
      check_reg("ret_idle", 4'hC, 0);
      pulses = 0;
      repeat (3) begin
         tick();
         if (timerInterrupt) pulses++;
      end
      check("ret_no_pulse", pulses, 0);

      // match while in service is delivered after return
      wr(4'h4, m_time + 3);
      wait_irq(10);
      tick();
      check_reg("svc2", 4'hC, 2);
      wr(4'h4, m_time + 2);
      repeat (2) tick();
      check_reg("svc_pend", 4'hC, 3);
      trap = 1;
      tick();
      trap = 0;
      check("after_ret_irq", {31'd0, timerInterrupt}, 0);
      check_reg("after_ret_st", 4'hC, 1);
      tick();
      check("deliver_irq", {31'd0, timerInterrupt}, 1);
      tick();
      trap = 1;
      tick();
      trap = 0;

      // prescaler
      wr(4'h4, 32'hFFFF_FFFF);
      wr(4'h8, 32'h303);
      wr(4'h0, 32'd0);
      repeat (4) tick();
      check_reg("pre_4", 4'h0, PRE ? 32'd1 : 32'd4);
      repeat (4) tick();
      check_reg("pre_8", 4'h0, PRE ? 32'd2 : 32'd8);
      check_reg("pre_ctrl", 4'h8, PRE ? 32'h303 : 32'h3);

      // wrap with irq disabled, then enable
      wr(4'h8, 32'h1);
      wr(4'h0, 32'hFFFF_FFFE);
      check("wrap_m0", {31'd0, timerMatch}, 0);
      tick();
      check("wrap_m1", {31'd0, timerMatch}, 1);
      tick();
      check_reg("wrap_time", 4'h0, 0);
      check("wrap_m2", {31'd0, timerMatch}, 0);
      check_reg("wrap_pend", 4'hC, 1);
      pulses = 0;
      repeat (3) begin
         tick();
         if (timerInterrupt) pulses++;
      end
      check("wrap_no_pulse", pulses, 0);
      check_reg("wrap_held", 4'hC, 1);
      wr(4'h8, 32'h3);
      check("irqen_0", {31'd0, timerInterrupt}, 0);
      tick();
      check("irqen_1", {31'd0, timerInterrupt}, 1);
      tick();
      check("irqen_2", {31'd0, timerInterrupt}, 0);
      trap = 1;
      tick();
      trap = 0;

      // reset during FIRE
      wr(4'h4, m_time + 2);
      wait_irq(10);
      reset = 1;
      model_reset();
      #1;
      check("rst_fire_irq", {31'd0, timerInterrupt}, 0);
      check_reg("rst_f_time", 4'h0, 0);
      check_reg("rst_f_cmp", 4'h4, 32'hFFFF_FFFF);
      check_reg("rst_f_ctrl", 4'h8, 0);
      check_reg("rst_f_stat", 4'hC, 0);
      @(posedge clk);
      #1;
      reset = 0;

      // random traffic against the model
      for (int i = 0; i < 500; i++) begin
         r = $urandom_range(0, 9);
         trap = ($urandom_range(0, 5) == 0);
         a = 2'($urandom_range(0, 3));
         case (a)
            2'd0: d = $urandom_range(0, 40);
            2'd1: d = m_time + $urandom_range(0, 10);
            2'd2: begin
               d = $urandom;
               d[15:8] = 8'($urandom_range(0, 2));
               d[0] = ($urandom_range(0, 3) != 0);
            end
            default: d = $urandom;
         endcase
         if (r < 4) begin
            cs = 1; we = 1;
         end else if (r == 4) begin
            cs = 0; we = 1;
         end
         addr = {a, 2'($urandom_range(0, 3))};
         wdata = d;
         tick();
         cs = 0; we = 0; trap = 0; addr = 0; wdata = 0;
         check("rnd_irq", {31'd0, timerInterrupt}, {31'd0, m_firing});
         check("rnd_match", {31'd0, timerMatch}, {31'd0, m_match()});
         a = 2'($urandom_range(0, 3));
         t = m_read(a);
         check_reg("rnd_read", {a, 2'b00}, t);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/machine_timer.md
# machine_timer

Memory-mapped machine timer that generates the `timerInterrupt` input of the instruction controller. It keeps a free-running `mtime` counter with an optional prescaler and compares it against `mtimecmp`. On a match it issues exactly one single-cycle interrupt pulse, then stays masked until the controller decodes the trap return (`isReturn`). The data-memory bus decoder selects it through `chipSelect`. Its interrupt output feeds the controller directly.

## Interface
- `RESET_COMPARE`, default 32'hFFFF_FFFF: reset value of `mtimecmp`, chosen so no match occurs out of reset.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `chipSelect`  in  1  bus access targets this block.
- `busAddress`  in  4  byte offset; bits [3:2] select the register, bits [1:0] are ignored.
- `writeEnable`  in  1  write strobe; it is only effective when `chipSelect` is high.
- `writeData`  in  32  write data.
- `readData`  out  32  combinational read of the selected register; reads 0 when `chipSelect` is low.
- `trapReturn`  in  1  driven by the controller's `isReturn`; ends interrupt service.
- `timerInterrupt`  out  1  registered one-cycle pulse to the controller.
- `timerMatch`  out  1  level `enable && (mtime >= mtimecmp)`, for debug and observation.

## Operation
- Register map:
  - 0x0 `mtime` (read/write).
  - 0x4 `mtimecmp` (read/write).
  - 0x8 `control`: bit0 `enable`, bit1 `irqEnable`, bits[15:8] `prescale`; all other bits read 0.
  - 0xC `status`: bit0 `pending` (write 1 to clear), bit1 `inService` (read-only).
- Counting:
  - While `enable` is set, the 8-bit prescale counter counts 0..`prescale`.
  - `mtime` increments when the prescale counter equals `prescale`, at which point the counter returns to 0.
  - `prescale` = 0 means `mtime` increments every cycle.
  - `mtime` wraps from 32'hFFFF_FFFF to 0. The comparison is unsigned.
- Match edge:
  - `match` = `enable && mtime >= mtimecmp`, computed from registered values.
  - `matchPrev` holds the previous cycle's `match`.
  - When `match && !matchPrev`, `pending` is set.
  - Any write to `mtimecmp` clears `matchPrev`. If the match is still true after the write, it therefore re-arms.
- State machine:
  - IDLE -> FIRE when `pending && irqEnable`; `pending` is cleared on this transition.
  - FIRE -> INSERVICE unconditionally, after one cycle.
  - INSERVICE -> IDLE when `trapReturn`.
  - `timerInterrupt` = (state == FIRE). `status.inService` = (state != IDLE).
- Write priority:
  - A bus write to `mtime` overrides the increment in that cycle and resets the prescale counter to 0.
  - Clearing `enable` freezes `mtime` and the prescale counter; both keep their values.

## Timing
- Reset values: `mtime` 0, `mtimecmp` `RESET_COMPARE`, `control` 0, `pending` 0, `matchPrev` 0, prescale counter 0, state IDLE. Outputs: `timerInterrupt` 0, `timerMatch` 0.
- Latency: if the `mtime` register first equals `mtimecmp` in cycle N, `pending` is high in N+1 and `timerInterrupt` is high in N+2 only.
- A held match (level stays true) never re-fires. The handler must rewrite `mtimecmp` to get a new pulse.
- A match arriving while in FIRE or INSERVICE sets `pending`. It is delivered one cycle after the return to IDLE, provided `irqEnable` is set.
- `pending` with `irqEnable` = 0 is held and fires the cycle after `irqEnable` is set.
- Set and clear of `pending` in the same cycle (edge plus W1C write): set wins.
- `trapReturn` in IDLE or FIRE is ignored.
- Reset asserted mid-service forces IDLE immediately. `timerInterrupt` drops asynchronously.

## Configuration
- `MACHINE_TIMER_PRESCALER_EN` defined: the prescaler exists as described above.
- Not defined: no prescale counter is built; `mtime` increments every cycle while `enable` is set; `control` bits[15:8] ignore writes and read 0.

## Test plan
- Reset, then enable counting with `prescale` = 0 and `mtimecmp` = 5. Required: `mtime` reads 5 after 5 enabled cycles, and `timerInterrupt` is high for exactly one cycle, 2 cycles after `mtime` = 5.
- After that fire, hold the match for 20 cycles without `trapReturn`. Required: no second pulse and `inService` = 1. Then pulse `trapReturn` with no new match. Required: state IDLE and no pulse.
- While in INSERVICE, rewrite `mtimecmp` to `mtime`+2. Required: `pending` = 1 at the match. Then assert `trapReturn`. Required: `timerInterrupt` pulses one cycle after the return to IDLE.
- `prescale` = 3 and `mtime` = 0. Required: `mtime` = 1 after 4 cycles and 2 after 8 cycles. Without the macro: `mtime` = 8 after 8 cycles and `control` reads 0x3.
- Write `mtime` = 32'hFFFF_FFFE with `mtimecmp` = 32'hFFFF_FFFF and `irqEnable` = 0. Required: `pending` sets, `mtime` wraps to 0, `timerMatch` falls, and no pulse occurs. Then set `irqEnable`. Required: one pulse one cycle later.
- Assert `reset` during FIRE. Required: `timerInterrupt` is 0 immediately and all registers return to reset values, with `mtimecmp` = 32'hFFFF_FFFF.
